// File: rtl/alu_seq.sv
// alu_seq: instruction sequencer and 4 x 8-bit register file driving a
// registered 8-bit ALU as its initiator.
//
// The ALU has two-edge latency. It samples A/B/CTR on one edge and registers
// O on the next. The sequencer issues operands on the accept edge, waits out
// that latency, then writes the ALU result back to the destination register.
//
// Optional feature: define ALU_SEQ_LDI_EN to enable opcode 0010 (LDI, load
// immediate). When it is undefined, 0010 is rejected as illegal and in_imm
// is unused.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | in_ready high; accepts an instruction (LDI/illegal finish here)
// ST_ISSUE | operands on alu_a/alu_b/alu_ctr; the ALU samples them next edge
// ST_WAIT  | the ALU registers its result on the next edge
// ST_CAPT  | alu_o is valid; written back to R[rd] on the next edge
module alu_seq (
  input  logic       ck,
  input  logic       rstn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [1:0] in_rd,
  input  logic [1:0] in_rs1,
  input  logic [1:0] in_rs2,
  input  logic [7:0] in_imm,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_ctr,
  input  logic [7:0] alu_o,
  output logic [7:0] res,
  output logic       res_valid,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CAPT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_ALU = 2'd0,
    K_LDI = 2'd1,
    K_ILL = 2'd2
  } kind_t;

  state_t     state;
  kind_t      kind;
  logic [7:0] regs [4];
  logic [1:0] rd_q;

  logic       accept;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [7:0] wr_data;
  logic [7:0] imm_data;

`ifdef ALU_SEQ_LDI_EN
  assign imm_data = in_imm;
`else
  // Immediate has no consumer in this build; fold it away explicitly.
  logic unused_imm;
  assign unused_imm = ^in_imm;
  assign imm_data   = 8'h00;
`endif

  // An instruction is taken only while idle; in_valid during busy states is ignored.
  assign accept = (state == ST_IDLE) && in_valid;

  // Classify the offered opcode as ALU operation, load-immediate or illegal.
  always_comb begin
    kind = K_ILL;
    casez (in_op)
      4'b0000, 4'b0001, 4'b1???: kind = K_ALU;
`ifdef ALU_SEQ_LDI_EN
      4'b0010:                   kind = K_LDI;
`endif
      default:                   kind = K_ILL;
    endcase
  end

  // Single register-file write port: LDI on the accept edge, ALU result on CAPT.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = rd_q;
    wr_data = alu_o;
    if (state == ST_CAPT) begin
      wr_en   = 1'b1;
      wr_idx  = rd_q;
      wr_data = alu_o;
    end else if (accept && (kind == K_LDI)) begin
      wr_en   = 1'b1;
      wr_idx  = in_rd;
      wr_data = imm_data;
    end
  end

  // Register file R0..R3, cleared on reset, no hardwired entry.
  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else if (wr_en) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // Result reporting: res follows every write, res_valid/err are one-cycle pulses.
  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn) begin
      res       <= 8'h00;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      res_valid <= wr_en;
      err       <= accept && (kind == K_ILL);
      if (wr_en) res <= wr_data;
    end
  end

  // Sequencer FSM with registered handshake and ALU operand outputs.
  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      in_ready <= 1'b1;
      alu_a    <= 8'h00;
      alu_b    <= 8'h00;
      alu_ctr  <= 4'h0;
      rd_q     <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          // LDI and illegal ops complete here; only ALU ops leave IDLE.
          if (accept && (kind == K_ALU)) begin
            alu_a    <= regs[in_rs1];
            alu_b    <= regs[in_rs2];
            alu_ctr  <= in_op;
            rd_q     <= in_rd;
            state    <= ST_ISSUE;
            in_ready <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          state <= ST_CAPT;
        end
        ST_CAPT: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq with a behavioural two-stage
// ALU attached and a register-file reference model kept in the bench.
module tb_alu_seq;

  logic       ck;
  logic       rstn;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_rd;
  logic [1:0] in_rs1;
  logic [1:0] in_rs2;
  logic [7:0] in_imm;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_ctr;
  logic [7:0] alu_o;
  logic [7:0] res;
  logic       res_valid;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Reference state: register contents, last issued opcode, last result.
  logic [7:0] mreg [4];
  logic [3:0] mctr;
  logic [7:0] mres;

  alu_seq dut (
    .ck        (ck),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctr   (alu_ctr),
    .alu_o     (alu_o),
    .res       (res),
    .res_valid (res_valid),
    .err       (err)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [7:0] r;
    case (op)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b1000: r = a & b;
      4'b1001: r = a | b;
      4'b1010: r = a ^ b;
      4'b1011: r = ~a;
      4'b1100: r = a >> 1;
      4'b1101: r = a << 1;
      4'b1110: r = (a >> 1) | (a << 7);
      4'b1111: r = (a << 1) | (a >> 7);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Behavioural ALU: samples A/B/CTR on one edge, registers O on the next.
  logic [7:0] alu_sa, alu_sb;
  logic [3:0] alu_sc;
  always @(posedge ck) begin
    alu_sa <= alu_a;
    alu_sb <= alu_b;
    alu_sc <= alu_ctr;
    alu_o  <= alu_ref(alu_sc, alu_sa, alu_sb);
  end

  // 0 = ALU op, 1 = LDI, 2 = illegal
  function automatic int kind_of(input logic [3:0] op);
    if (op == 4'b0000 || op == 4'b0001 || op >= 4'b1000) return 0;
`ifdef ALU_SEQ_LDI_EN
    if (op == 4'b0010) return 1;
`endif
    return 2;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    mctr = 4'h0;
    mres = 8'h00;
  endtask

  // Offer one instruction at a negedge while idle and follow it to completion.
  // Returns at the negedge after the instruction's result/err pulse has ended.
  task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic [7:0] imm);
    int k;
    logic [7:0] exp;
    k = kind_of(op);
    check("ready_before", {7'd0, in_ready}, 8'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    @(negedge ck);
    in_valid = 1'b0;
    if (k == 0) begin
      exp = alu_ref(op, mreg[rs1], mreg[rs2]);
      check("issue_a", alu_a, mreg[rs1]);
      check("issue_b", alu_b, mreg[rs2]);
      check("issue_ctr", {4'd0, alu_ctr}, {4'd0, op});
      check("issue_ready", {7'd0, in_ready}, 8'd0);
      check("issue_err", {7'd0, err}, 8'd0);
      mctr = op;
      repeat (2) begin
        @(negedge ck);
        check("busy_ready", {7'd0, in_ready}, 8'd0);
        check("busy_rv", {7'd0, res_valid}, 8'd0);
      end
      @(negedge ck);
      check("alu_rv", {7'd0, res_valid}, 8'd1);
      check("alu_res", res, exp);
      check("alu_ready", {7'd0, in_ready}, 8'd1);
      check("alu_err", {7'd0, err}, 8'd0);
      mreg[rd] = exp;
      mres     = exp;
    end else if (k == 1) begin
      check("ldi_rv", {7'd0, res_valid}, 8'd1);
      check("ldi_res", res, imm);
      check("ldi_ready", {7'd0, in_ready}, 8'd1);
      check("ldi_err", {7'd0, err}, 8'd0);
      mreg[rd] = imm;
      mres     = imm;
    end else begin
      check("ill_err", {7'd0, err}, 8'd1);
      check("ill_rv", {7'd0, res_valid}, 8'd0);
      check("ill_ready", {7'd0, in_ready}, 8'd1);
      check("ill_ctr", {4'd0, alu_ctr}, {4'd0, mctr});
      check("ill_res", res, mres);
    end
    @(negedge ck);
    check("pulse_rv_clear", {7'd0, res_valid}, 8'd0);
    check("pulse_err_clear", {7'd0, err}, 8'd0);
  endtask

  // Watchdog: the stimulus has no open-ended waits, this only guards against a stalled clock.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rop;
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_op    = 4'h0;
    in_rd    = 2'd0;
    in_rs1   = 2'd0;
    in_rs2   = 2'd0;
    in_imm   = 8'h00;
    model_reset();
    repeat (2) @(negedge ck);
    rstn = 1'b1;
    @(negedge ck);

    check("rst_ready", {7'd0, in_ready}, 8'd1);
    check("rst_res", res, 8'h00);
    check("rst_rv", {7'd0, res_valid}, 8'd0);
    check("rst_err", {7'd0, err}, 8'd0);
    check("rst_a", alu_a, 8'h00);
    check("rst_ctr", {4'd0, alu_ctr}, 8'h00);

    // Load R1/R2 with working values.
`ifdef ALU_SEQ_LDI_EN
    in_valid = 1'b1;
    in_op    = 4'b0010;
    in_rd    = 2'd1;
    in_imm   = 8'h3C;
    @(negedge ck);
    check("ldi1_rv", {7'd0, res_valid}, 8'd1);
    check("ldi1_res", res, 8'h3C);
    check("ldi1_ready", {7'd0, in_ready}, 8'd1);
    in_rd  = 2'd2;
    in_imm = 8'hA5;
    @(negedge ck);
    check("ldi2_rv", {7'd0, res_valid}, 8'd1);
    check("ldi2_res", res, 8'hA5);
    check("ldi2_ready", {7'd0, in_ready}, 8'd1);
    in_valid = 1'b0;
    mreg[1] = 8'h3C;
    mreg[2] = 8'hA5;
    mres    = 8'hA5;
    @(negedge ck);
    check("ldi_rv_clear", {7'd0, res_valid}, 8'd0);
`else
    send(4'b1011, 2'd1, 2'd0, 2'd0, 8'h00);  // R1 = ~R0
    send(4'b1101, 2'd2, 2'd1, 2'd0, 8'h00);  // R2 = R1 << 1
    send(4'b1110, 2'd2, 2'd2, 2'd0, 8'h00);  // R2 = ror R2
    send(4'b0010, 2'd3, 2'd0, 2'd0, 8'h5A);  // LDI disabled: illegal
`endif

    // Directed ALU operations on R1/R2.
    send(4'b0000, 2'd3, 2'd1, 2'd2, 8'h00);
`ifdef ALU_SEQ_LDI_EN
    check("const_add", mres, 8'hE1);
`endif
    send(4'b0001, 2'd3, 2'd1, 2'd2, 8'h00);
`ifdef ALU_SEQ_LDI_EN
    check("const_sub", mres, 8'h97);
`endif
    send(4'b1010, 2'd3, 2'd1, 2'd2, 8'h00);
`ifdef ALU_SEQ_LDI_EN
    check("const_xor", mres, 8'h99);
`endif
    send(4'b1111, 2'd3, 2'd1, 2'd0, 8'h00);
`ifdef ALU_SEQ_LDI_EN
    check("const_rol", mres, 8'h78);
`endif
    send(4'b1110, 2'd3, 2'd2, 2'd0, 8'h00);
`ifdef ALU_SEQ_LDI_EN
    check("const_ror", mres, 8'hD2);
`endif

    // Illegal opcode: err pulse, nothing written.
    send(4'b0101, 2'd1, 2'd1, 2'd1, 8'hFF);
    send(4'b0000, 2'd0, 2'd1, 2'd2, 8'h00);  // reads R1/R2, exposes any stray write

    // Back-to-back dependency with in_valid held high.
    in_valid = 1'b1;
    in_op    = 4'b0000;
    in_rd    = 2'd3;
    in_rs1   = 2'd1;
    in_rs2   = 2'd2;
    @(negedge ck);
    in_rd  = 2'd0;
    in_rs1 = 2'd3;
    in_rs2 = 2'd3;
    check("b2b_busy_ready", {7'd0, in_ready}, 8'd0);
    repeat (2) @(negedge ck);
    check("b2b_capt_ready", {7'd0, in_ready}, 8'd0);
    @(negedge ck);
    mreg[3] = alu_ref(4'b0000, mreg[1], mreg[2]);
    check("b2b_rv1", {7'd0, res_valid}, 8'd1);
    check("b2b_res1", res, mreg[3]);
    @(negedge ck);
    in_valid = 1'b0;
    check("b2b_second_accepted", {7'd0, in_ready}, 8'd0);
    check("b2b_second_a", alu_a, mreg[3]);
    repeat (3) @(negedge ck);
    mreg[0] = alu_ref(4'b0000, mreg[3], mreg[3]);
    mres    = mreg[0];
    mctr    = 4'b0000;
    check("b2b_rv2", {7'd0, res_valid}, 8'd1);
    check("b2b_res2", res, mreg[0]);
`ifdef ALU_SEQ_LDI_EN
    check("const_b2b", mres, 8'hC2);
`endif
    @(negedge ck);
    check("b2b_rv_clear", {7'd0, res_valid}, 8'd0);

    // Busy handshake: add offered during WAIT is ignored.
    in_valid = 1'b1;
    in_op    = 4'b1010;
    in_rd    = 2'd2;
    in_rs1   = 2'd1;
    in_rs2   = 2'd3;
    @(negedge ck);
    in_valid = 1'b0;
    @(negedge ck);
    in_valid = 1'b1;
    in_op    = 4'b0000;
    in_rd    = 2'd1;
    check("busy_ctr_wait", {4'd0, alu_ctr}, 8'h0A);
    @(negedge ck);
    in_valid = 1'b0;
    check("busy_ctr_capt", {4'd0, alu_ctr}, 8'h0A);
    mreg[2] = alu_ref(4'b1010, mreg[1], mreg[3]);
    mres    = mreg[2];
    mctr    = 4'b1010;
    @(negedge ck);
    check("busy_rv", {7'd0, res_valid}, 8'd1);
    check("busy_res", res, mreg[2]);
    @(negedge ck);
    check("busy_not_captured", {7'd0, in_ready}, 8'd1);
    check("busy_ctr_idle", {4'd0, alu_ctr}, 8'h0A);

    // Reset mid-ISSUE abandons the operation.
    in_valid = 1'b1;
    in_op    = 4'b0001;
    in_rd    = 2'd3;
    in_rs1   = 2'd2;
    in_rs2   = 2'd1;
    @(negedge ck);
    in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_ready", {7'd0, in_ready}, 8'd1);
    check("mid_rst_res", res, 8'h00);
    check("mid_rst_a", alu_a, 8'h00);
    check("mid_rst_b", alu_b, 8'h00);
    check("mid_rst_ctr", {4'd0, alu_ctr}, 8'h00);
    check("mid_rst_rv", {7'd0, res_valid}, 8'd0);
    check("mid_rst_err", {7'd0, err}, 8'd0);
    @(negedge ck);
    rstn = 1'b1;
    model_reset();
    repeat (5) begin
      @(negedge ck);
      check("post_rst_no_rv", {7'd0, res_valid}, 8'd0);
    end
    for (int i = 0; i < 4; i++) send(4'b0000, i[1:0], i[1:0], i[1:0], 8'h00);
    for (int i = 0; i < 4; i++) check("post_rst_reg", mreg[i], 8'h00);

    // Randomized instruction stream against the reference model.
    send(4'b1011, 2'd1, 2'd0, 2'd0, 8'h00);
    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom_range(0, 15));
      send(rop, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end

    // Final readback of every register through an OR with itself.
    for (int i = 0; i < 4; i++) send(4'b1001, i[1:0], i[1:0], i[1:0], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Instruction sequencer and 4×8-bit register file that drives the registered 8-bit ALU (`A`, `B`, `CTR`, `O`, clock `ck`) as its initiator. It accepts one instruction at a time over a valid/ready handshake, reads the operands from the register file, and issues them to the ALU. It absorbs the ALU's two-edge latency, writes the ALU result back to the destination register, and reports each result on a one-cycle pulse.

## Interface
Parameters:
- none; widths are fixed to match the ALU: data 8, op 4, register index 2.

Ports:
- `ck`  in  1  clock, all state on rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  instruction offered
- `in_ready`  out  1  sequencer can accept an instruction (high only in IDLE)
- `in_op`  in  4  ALU opcode: 0000 add, 0001 sub, 1000 and, 1001 or, 1010 xor, 1011 not A, 1100 shr, 1101 shl, 1110 ror, 1111 rol; 0010 is LDI (see Configuration)
- `in_rd`  in  2  destination register
- `in_rs1`  in  2  source register for ALU port A
- `in_rs2`  in  2  source register for ALU port B
- `in_imm`  in  8  immediate for LDI; ignored otherwise
- `alu_a`, `alu_b`  out  8  to ALU `A`, `B`
- `alu_ctr`  out  4  to ALU `CTR`
- `alu_o`  in  8  from ALU `O`
- `res`  out  8  last written result
- `res_valid`  out  1  one-cycle pulse: `res` updated and register written
- `err`  out  1  one-cycle pulse: illegal opcode rejected

## Operation
- Register file R0..R3: 8 bits each, cleared on reset. No hardwired register.
- FSM states: IDLE → ISSUE → WAIT → CAPT → IDLE.
- Accept edge E0 (IDLE with `in_valid` high):
  - ALU op: register `alu_a`=R[rs1], `alu_b`=R[rs2], `alu_ctr`=op; latch rd; go to ISSUE.
- E1 (ISSUE→WAIT): the ALU samples its inputs.
- E2 (WAIT→CAPT): the ALU registers `O`.
- E3 (CAPT→IDLE): R[rd]←`alu_o`, `res`←`alu_o`, `res_valid`←1.
- Illegal op (0011–0111; also 0010 without the macro) at E0: `err`←1, no write, no ALU issue, stay IDLE.
- `alu_a`/`alu_b`/`alu_ctr` hold their last values when not issuing.
- `res_valid` and `err` each clear one cycle after they are set, unless set again.
- `in_valid` while `in_ready` is low is ignored; the instruction is not captured.
- Hazards: writes occur before the next accept, so the next instruction always reads updated registers. No forwarding logic is needed.
- Arithmetic: performed entirely in the ALU, 8-bit wrap. The sequencer never modifies data.
- Reset: asynchronous. All registers, `res`, `alu_*`, `res_valid`, `err` go to 0; state goes to IDLE; `in_ready` is 1. An in-flight operation is abandoned. The ALU has no reset; stale `O` is never captured, because CAPT is reached only through ISSUE/WAIT.

## Timing
- ALU op latency: accept at E0 → `res_valid` high in the cycle after E3. `in_ready` is low for 3 cycles (ISSUE, WAIT, CAPT).
- Throughput: one ALU op per 4 cycles. A new accept may coincide with the `res_valid` cycle.
- LDI: written at E0; `res_valid` high in the following cycle; `in_ready` stays 1, so back-to-back LDI runs at one per cycle.
- Illegal op: `err` high in the cycle after E0; `in_ready` stays 1.
- Simultaneous `res_valid`/`err` cannot occur for the same instruction.

## Configuration
- `ALU_SEQ_LDI_EN` defined:
  - opcode 0010 = LDI: R[rd]←`in_imm`, `res`←`in_imm`, `res_valid` pulse.
- Undefined:
  - 0010 is illegal (`err` pulse);
  - `in_imm` is unused.

## Test plan
- Reset then idle: `rstn` low mid-ISSUE → all outputs 0, `in_ready`=1, no `res_valid` after release; subsequent reads of R0..R3 via add R0+R0 give 0x00.
- LDI chain (macro on): LDI R1=0x3C, LDI R2=0xA5 on consecutive cycles → two `res_valid` pulses, `res`=0x3C then 0xA5.
- ALU ops: R1=0x3C, R2=0xA5:
  - add R3=R1+R2 → `res`=0xE1 exactly 4 cycles after accept;
  - sub → 0x97;
  - xor → 0x99;
  - rol R1 → 0x78;
  - ror 0xA5 → 0xD2.
- Back-to-back dependency: add R3=R1+R2 then add R0=R3+R3, with `in_valid` held high → second accept in the `res_valid` cycle, `res`=0xC2.
- Illegal op 0101 (and 0010 with macro off) → `err` pulse, registers unchanged, `in_ready` never drops.
- Busy handshake: `in_valid` asserted during WAIT with op add → not captured; `alu_ctr` is unchanged until the sequencer returns to IDLE.
